// File: rtl/basic_motor_pkg.sv
// Shared types for the line-following motor controller.
// State, turn-memory and motor-command encodings.
package basic_motor_pkg;

  typedef enum logic [2:0] {
    ST_STOP       = 3'd0,
    ST_FORWARD    = 3'd1,
    ST_TURN_LEFT  = 3'd2,
    ST_TURN_RIGHT = 3'd3,
    ST_SEARCH     = 3'd4
  } state_e;

  typedef enum logic {
    LT_LEFT  = 1'b0,
    LT_RIGHT = 1'b1
  } turn_e;

  typedef struct packed {
    logic left_dir;
    logic right_dir;
    logic left_act;
    logic right_act;
  } motor_cmd_t;

  function automatic motor_cmd_t motor_cmd(
    input state_e st,
    input turn_e  lt
  );
    motor_cmd_t c;
    c = '{left_dir: 1'b1, right_dir: 1'b1,
          left_act: 1'b0, right_act: 1'b0};
    unique case (st)
      ST_FORWARD: begin
        c.left_act  = 1'b1;
        c.right_act = 1'b1;
      end
      ST_TURN_LEFT:  c.right_act = 1'b1;
      ST_TURN_RIGHT: c.left_act  = 1'b1;
      ST_SEARCH: begin
        // pivot in place toward the side the wire was last seen
        c.left_dir  = (lt == LT_RIGHT);
        c.right_dir = (lt == LT_LEFT);
        c.left_act  = 1'b1;
        c.right_act = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/basic_motor_sensor_filter.sv
// Two-flop synchronizer followed by a stability filter.
// Output follows input only after FILTER_CYCLES equal samples.
module sensor_filter #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam logic [7:0] FC = 8'(FILTER_CYCLES);

  logic [WIDTH-1:0] meta_q, sync_q, last_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [7:0]       cnt_q, cnt_d, cnt_n;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    cnt_n  = (sync_q != last_q) ? 8'd1 : cnt_q + 8'd1;
    if (sync_q != filt_q) begin
      if (cnt_n >= FC) filt_d = sync_q;
      else             cnt_d  = cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      last_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      last_q <= sync_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/basic_motor.sv
// Line-following motor controller: filtered sensors drive a
// five-state FSM whose commands are PWM-gated onto the motors.
module basic_motor
  import basic_motor_pkg::*;
#(
  parameter int unsigned PWM_PERIOD     = 100,
  parameter int unsigned DUTY           = 75,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned SEARCH_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] induct,
  input  logic       proxim,
  output logic       leftOut,
  output logic       rightOut,
  output logic       leftEn,
  output logic       rightEn
);

  localparam logic [15:0] PWM_LAST = 16'(PWM_PERIOD - 1);
  localparam logic [31:0] SRCH_LAST = 32'(SEARCH_TIMEOUT - 1);

  logic [2:0]  ind_f;
  logic        prx_f;

  state_e      state_q, state_d;
  turn_e       last_turn_q, last_turn_d;
  logic [15:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0] search_cnt_q, search_cnt_d;
  logic        pwm_on;
  motor_cmd_t  cmd;
  logic        left_out_d, right_out_d;
  logic        left_en_d, right_en_d;

  sensor_filter #(
    .WIDTH        (3),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_induct_filt (
    .clk (clk),
    .rst (rst),
    .din (induct),
    .dout(ind_f)
  );

  sensor_filter #(
    .WIDTH        (1),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_proxim_filt (
    .clk (clk),
    .rst (rst),
    .din (proxim),
    .dout(prx_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STOP;
      last_turn_q  <= LT_LEFT;
      pwm_cnt_q    <= '0;
      search_cnt_q <= '0;
      leftOut      <= 1'b0;
      rightOut     <= 1'b0;
      leftEn       <= 1'b0;
      rightEn      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_turn_q  <= last_turn_d;
      pwm_cnt_q    <= pwm_cnt_d;
      search_cnt_q <= search_cnt_d;
      leftOut      <= left_out_d;
      rightOut     <= right_out_d;
      leftEn       <= left_en_d;
      rightEn      <= right_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (prx_f) begin
      state_d = ST_STOP;
    end else begin
      unique case (1'b1)
        (ind_f == 3'b010) || (ind_f == 3'b111):
          state_d = ST_FORWARD;
        (ind_f == 3'b100) || (ind_f == 3'b110):
          state_d = ST_TURN_LEFT;
        (ind_f == 3'b001) || (ind_f == 3'b011):
          state_d = ST_TURN_RIGHT;
        (ind_f == 3'b101): begin
          if (state_q == ST_STOP || state_q == ST_SEARCH)
            state_d = ST_FORWARD;
        end
        (ind_f == 3'b000): begin
          if (state_q == ST_FORWARD ||
              state_q == ST_TURN_LEFT ||
              state_q == ST_TURN_RIGHT)
            state_d = ST_SEARCH;
          else if (state_q == ST_SEARCH &&
                   search_cnt_q == SRCH_LAST)
            state_d = ST_STOP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    last_turn_d = last_turn_q;
    if (state_d == ST_TURN_LEFT)  last_turn_d = LT_LEFT;
    if (state_d == ST_TURN_RIGHT) last_turn_d = LT_RIGHT;

    search_cnt_d = '0;
    if (state_q == ST_SEARCH && state_d == ST_SEARCH)
      search_cnt_d = search_cnt_q + 32'd1;

    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 16'd1;
    pwm_on    = ({16'h0, pwm_cnt_q} < DUTY);
  end

  // outputs are registered from the next state so they move with it
  always_comb begin
    cmd         = motor_cmd(state_d, last_turn_d);
    left_out_d  = cmd.left_dir;
    right_out_d = cmd.right_dir;
    left_en_d   = cmd.left_act & pwm_on;
    right_en_d  = cmd.right_act & pwm_on;
  end

endmodule

// File: tb/tb_basic_motor.sv
// Directed bench for basic_motor: scoreboard of expected motor
// commands, checked after the filter/FSM latency.
module tb_basic_motor;

  typedef struct packed {
    logic l_dir;
    logic r_dir;
    logic l_act;
    logic r_act;
  } exp_t;

  localparam exp_t E_FWD  = 4'b1111;
  localparam exp_t E_TL   = 4'b1101;
  localparam exp_t E_TR   = 4'b1110;
  localparam exp_t E_STOP = 4'b1100;
  localparam exp_t E_SL   = 4'b0111;
  localparam exp_t E_SR   = 4'b1011;
  localparam exp_t E_RST  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] induct;
  logic       proxim;
  logic       leftOut, rightOut, leftEn, rightEn;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  basic_motor dut (
    .clk     (clk),
    .rst     (rst),
    .induct  (induct),
    .proxim  (proxim),
    .leftOut (leftOut),
    .rightOut(rightOut),
    .leftEn  (leftEn),
    .rightEn (rightEn)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] ind,
                       input logic prx,
                       input exp_t e);
    induct = ind;
    proxim = prx;
    sb.push_back(e);
  endtask

  task automatic pop(output exp_t e);
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: queue empty");
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
  endtask

  task automatic window(input string tag, input exp_t e);
    int lc = 0;
    int rc = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      lc += int'(leftEn);
      rc += int'(rightEn);
    end
    check({tag, "_len"}, lc, e.l_act ? 75 : 0);
    check({tag, "_ren"}, rc, e.r_act ? 75 : 0);
  endtask

  task automatic settle(input string tag, input int n);
    exp_t e;
    tick(n);
    pop(e);
    check({tag, "_dir"}, {30'b0, leftOut, rightOut},
          {30'b0, e.l_dir, e.r_dir});
    window(tag, e);
  endtask

  initial begin
    exp_t e;
    rst    = 1'b1;
    induct = 3'b000;
    proxim = 1'b0;
    sb.push_back(E_RST);
    tick(2);
    pop(e);
    check("reset", {leftOut, rightOut, leftEn, rightEn}, e);
    rst = 1'b0;
    tick(1);

    drive(3'b010, 1'b0, E_FWD);  settle("fwd", 7);
    drive(3'b101, 1'b0, E_FWD);  settle("amb_hold", 7);
    drive(3'b001, 1'b0, E_TR);   settle("tr_001", 7);
    drive(3'b011, 1'b0, E_TR);   settle("tr_011", 7);
    drive(3'b100, 1'b0, E_TL);   settle("tl_100", 7);
    drive(3'b110, 1'b0, E_TL);   settle("tl_110", 7);
    drive(3'b010, 1'b0, E_FWD);  settle("fwd2", 7);

    sb.push_back(E_FWD);
    induct = 3'b100;
    tick(3);
    induct = 3'b010;
    settle("glitch", 0);

    drive(3'b010, 1'b1, E_STOP); settle("prox_stop", 7);
    drive(3'b010, 1'b0, E_FWD);  settle("prox_resume", 7);
    drive(3'b001, 1'b0, E_TR);   settle("tr_pre_srch", 7);

    drive(3'b000, 1'b0, E_SR);
    tick(6);
    check("srch_lat_pre", {31'b0, rightOut}, 32'd1);
    settle("srch_r", 1);
    tick(899);
    check("srch_pre_to", {31'b0, rightOut}, 32'd0);
    sb.push_back(E_STOP);
    settle("srch_timeout", 1);

    drive(3'b100, 1'b0, E_TL);   settle("tl_pre_rst", 7);
    rst = 1'b1;
    sb.push_back(E_RST);
    tick(1);
    pop(e);
    check("mid_reset", {leftOut, rightOut, leftEn, rightEn}, e);
    rst    = 1'b0;
    induct = 3'b000;
    tick(1);

    drive(3'b001, 1'b0, E_TR);   settle("tr_post_rst", 7);
    drive(3'b100, 1'b0, E_TL);   settle("tl_post_rst", 7);
    drive(3'b000, 1'b0, E_SL);   settle("srch_l", 7);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
